simon_tone_player: RTL and testbench

Parametrised tone engine for the Simon game: generates a 50%-duty square wave on `speaker` for the four colour tones, plus multi-note success and failure jingles with timed notes and inter-note gaps. Sits between the game controller and the speaker pin. The controller issues a one-cycle `start` and then waits for `done`. Note periods, note length and gap length are parameters, so the same block serves both synthesis (100 MHz) and fast simulation.

---
 rtl/simon_tone_player.sv | 217 +++++++++++++++++++++
 tb/tb_simon_tone_player.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_tone_player.sv
// Square-wave tone engine for the Simon game: colour tones (timed or held) and
// success/failure jingles built from timed notes separated by silent gaps.
module simon_tone_player #(
    parameter int unsigned PERIOD_W    = 21,
    parameter int unsigned DUR_W       = 26,
    parameter int unsigned TONE_GREEN  = 227272,
    parameter int unsigned TONE_RED    = 202478,
    parameter int unsigned TONE_BLUE   = 170262,
    parameter int unsigned TONE_YELLOW = 151686,
    parameter int unsigned TONE_FAIL   = 135136,
    parameter int unsigned TONE_WIN    = 113636,
    parameter int unsigned NOTE_DUR    = 25000000,
    parameter int unsigned GAP_DUR     = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [1:0] tone_select,
    input  logic       hold,
    input  logic       abort,
    output logic       speaker,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] MODE_TIMED = 2'd0;
    localparam logic [1:0] MODE_HELD  = 2'd1;
    localparam logic [1:0] MODE_WIN   = 2'd2;
    localparam logic [1:0] MODE_FAIL  = 2'd3;

    localparam logic [1:0] SEL_GREEN  = 2'd0;
    localparam logic [1:0] SEL_RED    = 2'd1;
    localparam logic [1:0] SEL_BLUE   = 2'd2;
    localparam logic [1:0] SEL_YELLOW = 2'd3;

    localparam logic [PERIOD_W-1:0] P_GREEN  = PERIOD_W'(TONE_GREEN);
    localparam logic [PERIOD_W-1:0] P_RED    = PERIOD_W'(TONE_RED);
    localparam logic [PERIOD_W-1:0] P_BLUE   = PERIOD_W'(TONE_BLUE);
    localparam logic [PERIOD_W-1:0] P_YELLOW = PERIOD_W'(TONE_YELLOW);
    localparam logic [PERIOD_W-1:0] P_FAIL   = PERIOD_W'(TONE_FAIL);
    localparam logic [PERIOD_W-1:0] P_WIN    = PERIOD_W'(TONE_WIN);

    localparam logic [DUR_W-1:0] NOTE_LAST = DUR_W'(NOTE_DUR - 1);
    localparam logic [DUR_W-1:0] GAP_LAST  = DUR_W'(GAP_DUR - 1);
    localparam logic [DUR_W-1:0] DUR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state,   state_n;
    logic [PERIOD_W-1:0] period,  period_n;
    logic [PERIOD_W-1:0] pcnt,    pcnt_n;
    logic [PERIOD_W-1:0] pcnt_next;
    logic [DUR_W-1:0]    dcnt,    dcnt_n;
    logic [1:0]          note_no, note_no_n;
    logic [1:0]          mode_q,  mode_n;
    logic [1:0]          sel_q,   sel_n;
    logic                speaker_n, busy_n, done_n;
    logic                note_end;

    function automatic logic [PERIOD_W-1:0] colour_period(input logic [1:0] sel);
        logic [PERIOD_W-1:0] p;
        case (sel)
            SEL_GREEN:  p = P_GREEN;
            SEL_RED:    p = P_RED;
            SEL_BLUE:   p = P_BLUE;
            SEL_YELLOW: p = P_YELLOW;
            default:    p = P_GREEN;
        endcase
        return p;
    endfunction

    // Period of note number idx within the programme selected by m.
    function automatic logic [PERIOD_W-1:0] note_period(input logic [1:0] m,
                                                        input logic [1:0] sel,
                                                        input logic [1:0] idx);
        logic [PERIOD_W-1:0] p;
        case (m)
            MODE_WIN: begin
                case (idx)
                    2'd0:    p = P_BLUE;
                    2'd1:    p = P_YELLOW;
                    default: p = P_WIN;
                endcase
            end
            MODE_FAIL: p = P_FAIL;
            default:   p = colour_period(sel);
        endcase
        return p;
    endfunction

    function automatic logic [1:0] last_note(input logic [1:0] m);
        logic [1:0] n;
        case (m)
            MODE_WIN:  n = 2'd2;
            MODE_FAIL: n = 2'd1;
            default:   n = 2'd0;
        endcase
        return n;
    endfunction

    assign pcnt_next = (pcnt == period - PERIOD_W'(1)) ? '0 : pcnt + PERIOD_W'(1);
    assign note_end  = (mode_q == MODE_HELD) ? !hold : (dcnt == NOTE_LAST);

    always_comb begin
        state_n   = state;
        period_n  = period;
        pcnt_n    = pcnt;
        dcnt_n    = dcnt;
        note_no_n = note_no;
        mode_n    = mode_q;
        sel_n     = sel_q;
        speaker_n = speaker;
        busy_n    = busy;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n   = TONE;
                    mode_n    = mode;
                    sel_n     = tone_select;
                    note_no_n = 2'd0;
                    period_n  = note_period(mode, tone_select, 2'd0);
                    pcnt_n    = '0;
                    dcnt_n    = '0;
                    speaker_n = 1'b1;
                    busy_n    = 1'b1;
                end
            end

            TONE: begin
                if (abort) begin
                    state_n   = IDLE;
                    pcnt_n    = '0;
                    dcnt_n    = '0;
                    note_no_n = 2'd0;
                    speaker_n = 1'b0;
                    busy_n    = 1'b0;
                end else if (note_end) begin
                    pcnt_n    = '0;
                    dcnt_n    = '0;
                    speaker_n = 1'b0;
                    if (note_no < last_note(mode_q)) begin
                        state_n   = GAP;
                        note_no_n = note_no + 2'd1;
                    end else begin
                        state_n   = IDLE;
                        note_no_n = 2'd0;
                        busy_n    = 1'b0;
                        done_n    = 1'b1;
                    end
                end else begin
                    pcnt_n    = pcnt_next;
                    speaker_n = (pcnt_next < (period >> 1));
                    // Held notes can outlast the counter range; stick at the top.
                    dcnt_n    = (dcnt == DUR_MAX) ? dcnt : dcnt + DUR_W'(1);
                end
            end

            GAP: begin
                if (abort) begin
                    state_n   = IDLE;
                    dcnt_n    = '0;
                    note_no_n = 2'd0;
                    speaker_n = 1'b0;
                    busy_n    = 1'b0;
                end else if (dcnt == GAP_LAST) begin
                    state_n   = TONE;
                    period_n  = note_period(mode_q, sel_q, note_no);
                    pcnt_n    = '0;
                    dcnt_n    = '0;
                    speaker_n = 1'b1;
                end else begin
                    dcnt_n    = dcnt + DUR_W'(1);
                end
            end

            default: begin
                state_n   = IDLE;
                speaker_n = 1'b0;
                busy_n    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            period  <= '0;
            pcnt    <= '0;
            dcnt    <= '0;
            note_no <= 2'd0;
            mode_q  <= MODE_TIMED;
            sel_q   <= SEL_GREEN;
            speaker <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            period  <= period_n;
            pcnt    <= pcnt_n;
            dcnt    <= dcnt_n;
            note_no <= note_no_n;
            mode_q  <= mode_n;
            sel_q   <= sel_n;
            speaker <= speaker_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_simon_tone_player.sv
// Scoreboard bench for simon_tone_player using short simulation note timings.
module tb_simon_tone_player;

    typedef struct packed {
        logic spk;
        logic busy;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] tone_select = 2'd0;
    logic       hold = 1'b0;
    logic       abort = 1'b0;
    logic       speaker, busy, done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    simon_tone_player #(
        .PERIOD_W(8), .DUR_W(8),
        .TONE_GREEN(8), .TONE_RED(12), .TONE_BLUE(6), .TONE_YELLOW(4),
        .TONE_FAIL(10), .TONE_WIN(2), .NOTE_DUR(20), .GAP_DUR(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .tone_select(tone_select), .hold(hold), .abort(abort),
        .speaker(speaker), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Reference model: expected per-cycle outputs for programme fragments.
    task automatic push_note(input int p, input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e.spk  = ((i % p) < (p / 2));
            e.busy = 1'b1;
            e.done = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_gap(input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e = 3'b010;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_done();
        exp_t e;
        e = 3'b001;
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int len);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            e = 3'b000;
            exp_q.push_back(e);
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({speaker, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_initial: spk/busy/done=%b%b%b expected 000", speaker, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        mode = 2'd2; start = 1'b1;
        push_note(6, 20); push_gap(4); push_note(4, 20); push_gap(4); push_note(2, 20); push_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL reset_prenote cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({speaker, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: spk/busy/done=%b%b%b expected 000", speaker, busy, done);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push_idle(6);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
        end
    endtask

    task automatic test_mode0_green();
        exp_t e;
        int busy_cnt = 0;
        mode = 2'd0; tone_select = 2'd0; start = 1'b1;
        push_note(8, 20); push_done(); push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode0_green cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            if (busy) busy_cnt++;
            start = 1'b0;
        end
        n_checks++;
        if (busy_cnt !== 20) begin
            n_fail++;
            $display("FAIL mode0_busy_len: got %0d expected 20", busy_cnt);
        end
    endtask

    task automatic test_mode2_jingle();
        exp_t e;
        int busy_cnt = 0;
        mode = 2'd2; tone_select = 2'd1; start = 1'b1;
        push_note(6, 20); push_gap(4); push_note(4, 20); push_gap(4); push_note(2, 20);
        push_done(); push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode2_jingle cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            if (busy) busy_cnt++;
            start = 1'b0;
        end
        n_checks++;
        if (busy_cnt !== 68) begin
            n_fail++;
            $display("FAIL mode2_busy_len: got %0d expected 68", busy_cnt);
        end
    endtask

    task automatic test_mode1_hold();
        exp_t e;
        mode = 2'd1; tone_select = 2'd3; hold = 1'b1; start = 1'b1;
        push_note(4, 37); push_done(); push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode1_hold37 cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = 1'b0;
            hold  = (i < 36);
        end
        mode = 2'd1; tone_select = 2'd0; hold = 1'b0; start = 1'b1;
        push_note(8, 1); push_done(); push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode1_hold_low cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = 1'b0;
        end
    endtask

    task automatic test_mode3_abort();
        exp_t e;
        int busy_cnt = 0;
        // Abort on the second gap cycle.
        mode = 2'd3; tone_select = 2'd0; start = 1'b1;
        push_note(10, 20); push_gap(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode3_abort cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = 1'b0;
            abort = (i == 21);
            if (i == 21) push_idle(4);
        end
        // A start mid-note must be ignored, including its mode and colour.
        mode = 2'd3; start = 1'b1;
        push_note(10, 20); push_gap(4); push_note(10, 20); push_done(); push_idle(2);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL mode3_ignore_start cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            if (busy) busy_cnt++;
            start = (i == 5);
            if (i == 5) begin
                mode = 2'd0; tone_select = 2'd1;
            end
        end
        n_checks++;
        if (busy_cnt !== 44) begin
            n_fail++;
            $display("FAIL mode3_busy_len: got %0d expected 44", busy_cnt);
        end
        mode = 2'd0; start = 1'b1; abort = 1'b1;
        push_idle(4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL start_abort_idle cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = 1'b0; abort = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        mode = 2'd0; tone_select = 2'd2; start = 1'b1;
        push_note(6, 20); push_done();
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({speaker, busy, done} !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: spk/busy/done=%b%b%b expected %b", i, speaker, busy, done, e);
            end
            start = (i == 20);
            if (i == 20) begin
                tone_select = 2'd1;
                push_note(12, 20); push_done(); push_idle(2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_green();
        test_mode2_jingle();
        test_mode1_hold();
        test_mode3_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
